mem_dump_reader: RTL

Read-back engine for the multicycle MIPS board build: walks a range of data memory or the register bank, one word per step, and presents each word, with its index, for the seven-segment and LED outputs. It is the read-side counterpart of the switch-driven pre-fetch loader. The loader writes memory and registers from the switches; this block reads them back through the same debug read ports while the CPU is halted. It sits beside the loader in the top level and drives the display mux.

---
 rtl/dump_pkg.sv | 16 +
 rtl/rise_detect.sv | 18 +
 rtl/mem_dump_reader.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/dump_pkg.sv
// Shared types and default timing parameters for the memory/register dump reader.
package dump_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    SHOW,
    DONE
  } dump_state_t;

  localparam int unsigned DEF_ADDR_W      = 6;
  localparam int unsigned DEF_RD_LAT      = 1;
  localparam int unsigned DEF_HOLD_CYCLES = 50_000_000;

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector: pulse is high while in is 1 and was 0 on the previous cycle.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic pulse
);

  logic prev;

  always_ff @(posedge clk) begin
    if (rst) prev <= 1'b0;
    else     prev <= in;
  end

  assign pulse = in & ~prev;

endmodule

// File: rtl/mem_dump_reader.sv
// Read-back engine: walks data memory or the register bank one word per step and
// presents each captured word with its offset for the board display.
module mem_dump_reader
  import dump_pkg::*;
#(
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned RD_LAT      = DEF_RD_LAT,
  parameter int unsigned HOLD_CYCLES = DEF_HOLD_CYCLES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic        sel_reg,
  input  logic        auto,
  input  logic        step,
  input  logic [7:0]  base,
  input  logic [7:0]  count,
  output logic        rd_en,
  output logic [31:0] mem_addr,
  output logic [4:0]  reg_addr,
  input  logic [31:0] rd_data,
  output logic [31:0] disp_word,
  output logic [7:0]  disp_index,
  output logic        disp_valid,
  output logic        busy,
  output logic        done
);

  localparam int unsigned LAT_W  = (RD_LAT > 1)      ? $clog2(RD_LAT)      : 1;
  localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  dump_state_t       state, state_d;
  logic [7:0]        idx, idx_d;
  logic [LAT_W-1:0]  lat_cnt, lat_d;
  logic [HOLD_W-1:0] hold_cnt, hold_d;
  logic              sel_q, sel_d, auto_q, auto_d;
  logic [7:0]        base_q, base_d, count_q, count_d;
  logic [31:0]       word_d, mem_addr_d;
  logic [7:0]        index_d, sum;
  logic [4:0]        reg_addr_d;
  logic [ADDR_W-1:0] mem_idx;
  logic              valid_d, rd_en_d, busy_d, done_d;
  logic              step_rise, advance;

  rise_detect u_step_edge (
    .clk   (clk),
    .rst   (rst),
    .in    (step),
    .pulse (step_rise)
  );

  assign advance = auto_q ? (hold_cnt == HOLD_W'(HOLD_CYCLES - 1)) : step_rise;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d    = state;
    idx_d      = idx;
    lat_d      = lat_cnt;
    hold_d     = '0;
    sel_d      = sel_q;
    auto_d     = auto_q;
    base_d     = base_q;
    count_d    = count_q;
    word_d     = disp_word;
    index_d    = disp_index;
    valid_d    = disp_valid;
    mem_addr_d = mem_addr;
    reg_addr_d = reg_addr;
    sum        = '0;
    mem_idx    = '0;

    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          sel_d   = sel_reg;
          auto_d  = auto;
          base_d  = base;
          count_d = count;
          idx_d   = '0;
          valid_d = 1'b0;
          state_d = (count == 8'd0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        lat_d   = LAT_W'(RD_LAT - 1);
        state_d = WAIT;
      end
      WAIT: begin
        if (lat_cnt == '0) begin
          word_d  = rd_data;
          index_d = idx;
          valid_d = 1'b1;
          state_d = SHOW;
        end else begin
          lat_d = lat_cnt - LAT_W'(1);
        end
      end
      SHOW: begin
        hold_d = hold_cnt + HOLD_W'(1);
        if (advance) begin
          if (idx == count_q - 8'd1) begin
            state_d = DONE;
          end else begin
            idx_d   = idx + 8'd1;
            state_d = ISSUE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // abort overrides every other transition
    if (abort) begin
      state_d = IDLE;
      idx_d   = '0;
      valid_d = 1'b0;
    end

    // addresses are launched together with the read strobe
    if (state_d == ISSUE) begin
      sum     = base_d + idx_d;
      mem_idx = ADDR_W'(sum);
      if (sel_d) reg_addr_d = sum[4:0];
      else       mem_addr_d = 32'(mem_idx) << 2;
    end

    rd_en_d = (state_d == ISSUE);
    busy_d  = (state_d != IDLE) && (state_d != DONE);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx        <= '0;
      lat_cnt    <= '0;
      hold_cnt   <= '0;
      sel_q      <= 1'b0;
      auto_q     <= 1'b0;
      base_q     <= '0;
      count_q    <= '0;
      rd_en      <= 1'b0;
      mem_addr   <= '0;
      reg_addr   <= '0;
      disp_word  <= '0;
      disp_index <= '0;
      disp_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      idx        <= idx_d;
      lat_cnt    <= lat_d;
      hold_cnt   <= hold_d;
      sel_q      <= sel_d;
      auto_q     <= auto_d;
      base_q     <= base_d;
      count_q    <= count_d;
      rd_en      <= rd_en_d;
      mem_addr   <= mem_addr_d;
      reg_addr   <= reg_addr_d;
      disp_word  <= word_d;
      disp_index <= index_d;
      disp_valid <= valid_d;
      busy       <= busy_d;
      done       <= done_d;
    end
  end

endmodule
